// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants and the XOF packer state type
package kyber_pkg;

    localparam int KYBER_Q             = 3329;
    localparam int SHAKE128_RATE_BYTES = 168;
    localparam int XOF_STREAM_BYTES    = 672;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        LAUNCH,
        WAIT
    } xof_pack_state_t;

endpackage

// File: rtl/xof_stream_packer.sv
// rtl/xof_stream_packer.sv - packs SHAKE128 squeeze blocks into a sampler byte stream
module xof_stream_packer
    import kyber_pkg::*;
#(
    parameter int RATE_BYTES  = SHAKE128_RATE_BYTES,
    parameter int NUM_BLOCKS  = XOF_STREAM_BYTES / SHAKE128_RATE_BYTES,
    parameter int MAX_REFILLS = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [RATE_BYTES*8-1:0]            block_in,
    input  logic                               block_valid,
    output logic                               block_ready,
    output logic [RATE_BYTES*NUM_BLOCKS*8-1:0] byte_stream,
    output logic                               sampler_enable,
    input  logic                               sampler_done,
    input  logic                               need_more,
    output logic                               busy,
    output logic                               poly_done,
    output logic                               err
);

    // Counter widths never drop below one bit so degenerate parameter choices still elaborate.
    localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int RF_W  = (MAX_REFILLS > 0) ? $clog2(MAX_REFILLS + 1) : 1;

    localparam logic [BLK_W-1:0] LAST_BLK    = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [RF_W-1:0]  REFILL_LIMIT = RF_W'(MAX_REFILLS);

    xof_pack_state_t  state;
    logic [BLK_W-1:0] blk_cnt;
    logic [RF_W-1:0]  refill_cnt;

    // The packer only takes blocks while filling; elsewhere the producer must hold its block.
    always_comb begin
        block_ready = (state == FILL);
    end

    // Control FSM plus the block-slot write decoder; pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            blk_cnt        <= '0;
            refill_cnt     <= '0;
            byte_stream    <= '0;
            sampler_enable <= 1'b0;
            busy           <= 1'b0;
            poly_done      <= 1'b0;
            err            <= 1'b0;
        end else begin
            sampler_enable <= 1'b0;
            poly_done      <= 1'b0;
            err            <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        blk_cnt    <= '0;
                        refill_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (block_valid && block_ready) begin
                        byte_stream[int'(blk_cnt)*RATE_BYTES*8 +: RATE_BYTES*8] <= block_in;
                        if (blk_cnt == LAST_BLK) begin
                            // Enable is registered here so it is high for exactly the LAUNCH cycle.
                            blk_cnt        <= '0;
                            sampler_enable <= 1'b1;
                            state          <= LAUNCH;
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (sampler_done) begin
                        if (!need_more) begin
                            poly_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else if (refill_cnt < REFILL_LIMIT) begin
                            // Squeeze a fresh stream from the same XOF state, overwriting slot by slot.
                            refill_cnt <= refill_cnt + 1'b1;
                            state      <= FILL;
                        end else begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xof_stream_packer.sv
// tb/tb_xof_stream_packer.sv - self-checking bench for xof_stream_packer
module tb_xof_stream_packer;

    localparam int RB  = 168;
    localparam int NB  = 4;
    localparam int MR  = 3;
    localparam int NBY = RB * NB;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [RB*8-1:0]  block_in = '0;
    logic             block_valid = 1'b0;
    logic             block_ready;
    logic [NBY*8-1:0] byte_stream;
    logic             sampler_enable;
    logic             sampler_done = 1'b0;
    logic             need_more = 1'b0;
    logic             busy;
    logic             poly_done;
    logic             err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int c0;
    bit cmp_on = 1'b0;

    // Behavioural model: how many blocks are still owed, which slot is next, pass bookkeeping.
    bit         m_busy, m_launch, m_waiting, m_done, m_err;
    int         m_fill_left, m_slot, m_passes;
    logic [7:0] m_bytes [NBY];
    int         cmp_bad;

    xof_stream_packer #(
        .RATE_BYTES (RB),
        .NUM_BLOCKS (NB),
        .MAX_REFILLS(MR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .block_in      (block_in),
        .block_valid   (block_valid),
        .block_ready   (block_ready),
        .byte_stream   (byte_stream),
        .sampler_enable(sampler_enable),
        .sampler_done  (sampler_done),
        .need_more     (need_more),
        .busy          (busy),
        .poly_done     (poly_done),
        .err           (err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Model update on each rising edge, or immediately on reset.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0; m_launch = 0; m_waiting = 0; m_done = 0; m_err = 0;
            m_fill_left = 0; m_slot = 0; m_passes = 0;
            for (int k = 0; k < NBY; k++) m_bytes[k] = 8'h00;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_fill_left = NB; m_slot = 0; m_passes = 0;
                end
            end else if (m_fill_left > 0) begin
                if (block_valid) begin
                    for (int k = 0; k < RB; k++) m_bytes[m_slot*RB + k] = block_in[k*8 +: 8];
                    m_slot++;
                    m_fill_left--;
                    m_launch = (m_fill_left == 0);
                end
            end else if (m_launch) begin
                m_launch  = 0;
                m_waiting = 1;
            end else if (m_waiting && sampler_done) begin
                m_waiting = 0;
                if (!need_more) begin
                    m_done = 1; m_busy = 0;
                end else if (m_passes < MR) begin
                    m_passes++; m_fill_left = NB; m_slot = 0;
                end else begin
                    m_err = 1; m_busy = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            chk("cmp_block_ready", 32'(block_ready), 32'(m_fill_left > 0));
            chk("cmp_sampler_enable", 32'(sampler_enable), 32'(m_launch));
            chk("cmp_busy", 32'(busy), 32'(m_busy));
            chk("cmp_poly_done", 32'(poly_done), 32'(m_done));
            chk("cmp_err", 32'(err), 32'(m_err));
            cmp_bad = -1;
            for (int k = 0; k < NBY; k++)
                if (cmp_bad < 0 && byte_stream[k*8 +: 8] !== m_bytes[k]) cmp_bad = k;
            n_chk++;
            if (cmp_bad >= 0) begin
                n_fail++;
                $display("FAIL cmp_byte_stream: byte %0d got %02h expected %02h at %0t",
                         cmp_bad, byte_stream[cmp_bad*8 +: 8], m_bytes[cmp_bad], $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_block(input int j);
        for (int i = 0; i < RB; i++) block_in[i*8 +: 8] = 8'((j * 16 + (i % 16)) & 255);
    endtask

    task automatic feed(input int n, input int stall, input int first_j);
        logic r;
        bit   ok;
        for (int b = 0; b < n; b++) begin
            set_block(first_j + b);
            block_valid = 1'b1;
            ok = 0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                r = block_ready;
                @(posedge clk);
                #2;
                ok = r;
            end
            if (!ok) chk("feed_accept_timeout", 32'(ok), 32'd1);
            block_valid = 1'b0;
            if (b < n - 1) repeat (stall) tick();
        end
    endtask

    task automatic pulse_start();
        c0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pass_result(input logic more);
        sampler_done = 1'b1;
        need_more = more;
        c0 = cyc;
        tick();
        sampler_done = 1'b0;
        need_more = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_block_ready", 32'(block_ready), 32'd0);
        chk("reset_sampler_enable", 32'(sampler_enable), 32'd0);
        chk("reset_byte_stream_zero", 32'(byte_stream == '0), 32'd1);
        chk("reset_poly_done", 32'(poly_done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        cmp_on = 1'b1;
        tick();

        // Straight fill, one refill, then completion.
        pulse_start();
        feed(4, 0, 0);
        chk("t1_enable_latency", 32'(cyc - c0), 32'd5);
        chk("t1_enable", 32'(sampler_enable), 32'd1);
        chk("t1_blk1_byte0", 32'(byte_stream[168*8 +: 8]), 32'h10);
        chk("t1_blk3_byte5", 32'(byte_stream[(3*168+5)*8 +: 8]), 32'h35);
        tick();
        pass_result(1'b1);
        feed(4, 0, 4);
        chk("t3_refill_latency", 32'(cyc - c0), 32'd5);
        chk("t3_enable", 32'(sampler_enable), 32'd1);
        chk("t3_overwrite_byte0", 32'(byte_stream[7:0]), 32'h40);
        tick();
        pass_result(1'b0);
        chk("t3_poly_done", 32'(poly_done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_err", 32'(err), 32'd0);
        tick();

        // Producer stalls between blocks.
        pulse_start();
        feed(4, 3, 0);
        chk("t2_enable_latency", 32'(cyc - c0), 32'd14);
        chk("t2_enable", 32'(sampler_enable), 32'd1);
        tick();
        pass_result(1'b0);
        chk("t2_poly_done", 32'(poly_done), 32'd1);
        tick();

        // Refill budget exhausted.
        pulse_start();
        feed(4, 0, 0);
        for (int p = 0; p <= MR; p++) begin
            tick();
            pass_result(1'b1);
            if (p < MR) begin
                chk("t4_busy_mid", 32'(busy), 32'd1);
                chk("t4_err_mid", 32'(err), 32'd0);
                feed(4, 0, p + 1);
            end else begin
                chk("t4_err", 32'(err), 32'd1);
                chk("t4_poly_done", 32'(poly_done), 32'd0);
                chk("t4_busy", 32'(busy), 32'd0);
                chk("t4_block_ready", 32'(block_ready), 32'd0);
            end
        end
        tick();
        chk("t4_err_one_cycle", 32'(err), 32'd0);

        // Reset in the middle of a fill.
        pulse_start();
        feed(2, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("t5_block_ready", 32'(block_ready), 32'd0);
        chk("t5_byte_stream_zero", 32'(byte_stream == '0), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        pulse_start();
        feed(1, 0, 5);
        chk("t5_slot0_byte0", 32'(byte_stream[7:0]), 32'h50);
        chk("t5_slot1_byte0", 32'(byte_stream[RB*8 +: 8]), 32'h00);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        tick();

        // Spurious start in WAIT and sampler_done in IDLE.
        pulse_start();
        feed(4, 0, 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_block_ready", 32'(block_ready), 32'd0);
        chk("t6_enable", 32'(sampler_enable), 32'd0);
        pass_result(1'b0);
        chk("t6_poly_done", 32'(poly_done), 32'd1);
        pass_result(1'b1);
        chk("t6_idle_poly_done", 32'(poly_done), 32'd0);
        chk("t6_idle_err", 32'(err), 32'd0);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_idle_block_ready", 32'(block_ready), 32'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            start        = ($urandom_range(0, 9) == 0);
            block_valid  = ($urandom_range(0, 9) < 6);
            for (int w = 0; w < RB / 4; w++) block_in[w*32 +: 32] = $urandom;
            sampler_done = ($urandom_range(0, 3) == 0);
            need_more    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        block_valid = 1'b0;
        sampler_done = 1'b0;
        need_more = 1'b0;
        tick();
        tick();
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
